// File: rtl/fetch_prefetch_unit_if.sv
// ============================================================================
// Module : fetch_prefetch_unit_if
// Brief  : Memory read, redirect and decode handshake bundle for the fetch unit
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_prefetch_unit_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output mem_addr,
        input  mem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  mem_addr,
        output mem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );
endinterface

`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
// ============================================================================
// Module : fetch_prefetch_unit
// Brief  : Fetch PC + prefetch FIFO feeding decode; redirect flushes the buffer.
//          Optional macro FETCH_PERF_EN adds perf_fetched/perf_stall counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic              enable,
    input  wire logic              rst,
    fetch_prefetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_stall
`endif
);

    localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      word_q [DEPTH];
    logic [31:0]      word_d [DEPTH];
    logic [31:0]      pcs_q  [DEPTH];
    logic [31:0]      pcs_d  [DEPTH];
    logic             pop;
    logic             push;

    assign bus.mem_addr    = fetch_pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = word_q[rd_ptr_q];
    assign bus.instr_pc    = pcs_q[rd_ptr_q];

    always_comb begin
        pop        = bus.instr_valid & bus.instr_ready;
        push       = !bus.redirect_valid & ((count_q < C_DEPTH) | pop);
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        word_d     = word_q;
        pcs_d      = pcs_q;
        if (bus.redirect_valid) begin
            // A pop in the redirect cycle is dropped; decode squashes that head.
            fetch_pc_d = bus.redirect_pc & ~32'h0000_0003;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                word_d[wr_ptr_q] = bus.mem_rdata;
                pcs_d[wr_ptr_q]  = fetch_pc_q;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
                fetch_pc_d       = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge enable) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the head is only meaningful while count is non-zero.
    always_ff @(posedge enable) begin
        word_q <= word_d;
        pcs_q  <= pcs_d;
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + (push ? 32'd1 : 32'd0);
        perf_stall_d   = perf_stall_q + (((count_q == C_DEPTH) && !pop) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge enable) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
// ============================================================================
// Module : tb_fetch_prefetch_unit
// Brief  : Directed vector bench for fetch_prefetch_unit (DEPTH=4, RESET_PC=0).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_prefetch_unit;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        chk;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
    } vec_t;

    localparam int NV = 32;

    logic enable = 1'b0;
    logic rst    = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    vec_t vecs [NV];

    fetch_prefetch_unit_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_prefetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .enable       (enable),
        .rst          (rst),
        .bus          (bus.master)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 enable = ~enable;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + {2'b00, a[31:2]};
    endfunction

    assign bus.mem_rdata = mem_word(bus.mem_addr);

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    endtask

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                                input logic chk, input logic ev, input logic [31:0] epc,
                                input logic [31:0] eaddr);
        vec_t v;
        v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.chk = chk; v.ev = ev; v.epc = epc; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.instr_ready    = rdy;
    endtask

    initial begin
        // Each row: inputs for this cycle, expected outputs observed during it.
        //            rst  rv   rpc            rdy  chk  ev   epc            eaddr
        vecs[0]  = mk(1'b1,1'b0,32'h0,         1'b1,1'b0,1'b0,32'h0,         32'h0);
        vecs[1]  = mk(1'b1,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h0,         32'h0);
        vecs[2]  = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h0,         32'h0);
        vecs[3]  = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h0,         32'h4);
        vecs[4]  = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h4,         32'h8);
        vecs[5]  = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h8,         32'hC);
        vecs[6]  = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'hC,         32'h10);
        vecs[7]  = mk(1'b0,1'b0,32'h0,         1'b0,1'b1,1'b1,32'h10,        32'h14);
        vecs[8]  = mk(1'b0,1'b0,32'h0,         1'b0,1'b1,1'b1,32'h10,        32'h18);
        vecs[9]  = mk(1'b0,1'b0,32'h0,         1'b0,1'b1,1'b1,32'h10,        32'h1C);
        vecs[10] = mk(1'b0,1'b0,32'h0,         1'b0,1'b1,1'b1,32'h10,        32'h20);
        vecs[11] = mk(1'b0,1'b0,32'h0,         1'b0,1'b1,1'b1,32'h10,        32'h20);
        vecs[12] = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h10,        32'h20);
        vecs[13] = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h14,        32'h24);
        vecs[14] = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h18,        32'h28);
        vecs[15] = mk(1'b0,1'b0,32'h0,         1'b0,1'b1,1'b1,32'h1C,        32'h2C);
        vecs[16] = mk(1'b0,1'b1,32'h0000_0043, 1'b0,1'b1,1'b1,32'h1C,        32'h2C);
        vecs[17] = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h0,         32'h40);
        vecs[18] = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h40,        32'h44);
        vecs[19] = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h44,        32'h48);
        vecs[20] = mk(1'b0,1'b1,32'h0000_0100, 1'b1,1'b1,1'b1,32'h48,        32'h4C);
        vecs[21] = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h0,         32'h100);
        vecs[22] = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h100,       32'h104);
        vecs[23] = mk(1'b1,1'b1,32'h0000_0200, 1'b1,1'b1,1'b1,32'h104,       32'h108);
        vecs[24] = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h0,         32'h0);
        vecs[25] = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h0,         32'h4);
        vecs[26] = mk(1'b0,1'b1,32'hFFFF_FFF8, 1'b1,1'b1,1'b1,32'h4,         32'h8);
        vecs[27] = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b0,32'h0,         32'hFFFF_FFF8);
        vecs[28] = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'hFFFF_FFF8, 32'hFFFF_FFFC);
        vecs[29] = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'hFFFF_FFFC, 32'h0);
        vecs[30] = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h0,         32'h4);
        vecs[31] = mk(1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,32'h4,         32'h8);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            #1;
            if (vecs[i].chk) begin
                check("instr_valid", i, {31'd0, bus.instr_valid}, {31'd0, vecs[i].ev});
                check("mem_addr", i, bus.mem_addr, vecs[i].eaddr);
                if (vecs[i].ev) begin
                    check("instr_pc", i, bus.instr_pc, vecs[i].epc);
                    check("instr", i, bus.instr, mem_word(vecs[i].epc));
                end
            end
            @(posedge enable);
            #1;
        end

`ifdef FETCH_PERF_EN
        // 10 streaming cycles, 3 filling cycles, then 3 full stall cycles.
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (2) @(posedge enable);
        #1;
        check("perf_fetched_rst", 100, perf_fetched, 32'd0);
        check("perf_stall_rst", 100, perf_stall, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (10) @(posedge enable);
        #1;
        check("perf_fetched_stream", 101, perf_fetched, 32'd10);
        check("perf_stall_stream", 101, perf_stall, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (6) @(posedge enable);
        #1;
        check("perf_fetched_full", 102, perf_fetched, 32'd13);
        check("perf_stall_full", 102, perf_stall, 32'd3);
        drive(1'b1, 1'b1, 32'h40, 1'b0);
        @(posedge enable);
        #1;
        check("perf_fetched_clr", 103, perf_fetched, 32'd0);
        check("perf_stall_clr", 103, perf_stall, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode/RegFile path; drives the address input of Memory4KB and consumes its dataOut.
- Holds the fetch PC and issues one word read per cycle. Memory4KB read is combinational, so data returns in the same cycle as the address.
- Buffers fetched words with their PCs in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Supports a redirect input for branches and jumps that flushes the buffer.

Parameters:
- DEPTH, 4: prefetch FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: fetch PC loaded on reset; bits [1:0] must be 0.

Ports:
- enable  in  1  clock; all state updates on posedge enable.
- rst  in  1  synchronous active-high reset, sampled on posedge enable.
- mem_addr  out  32  word address to Memory4KB address input; combinational from fetch_pc.
- mem_rdata  in  32  Memory4KB dataOut for mem_addr, valid in the same cycle.
- redirect_valid  in  1  one-cycle pulse; discards all buffered state and restarts fetch.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0.
- instr_valid  out  1  FIFO head is valid.
- instr  out  32  FIFO head instruction word.
- instr_pc  out  32  PC of the FIFO head.
- instr_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Reset, synchronous, when rst=1 at posedge enable:
  - fetch_pc <= RESET_PC; FIFO count, read pointer and write pointer <= 0.
  - instr_valid=0. instr and instr_pc read the register contents, don't-care while instr_valid=0.
  - rst overrides redirect_valid and instr_ready in the same cycle.
- mem_addr = fetch_pc at all times, including during reset.
- Definitions:
  - pop = instr_valid & instr_ready.
  - push = !redirect_valid & (count < DEPTH | pop).
- Push:
  - Writes {fetch_pc, mem_rdata} at the write pointer.
  - Advances the write pointer (mod DEPTH).
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^32 (FFFF_FFFC -> 0000_0000).
- Pop: advances the read pointer (mod DEPTH).
- Count: push & pop leaves count unchanged; push only +1; pop only -1.
- Full (count==DEPTH):
  - No push unless a pop occurs in the same cycle.
  - fetch_pc holds, so mem_addr is stable while stalled.
- Empty (count==0): instr_valid=0. No bypass; a word pushed this cycle appears at the head the next cycle.
- Latency:
  - rst released in cycle 0, first push in cycle 0, instr_valid=1 in cycle 1 with instr_pc=RESET_PC.
  - Redirect in cycle N: head valid in cycle N+2, with instr_pc = aligned redirect_pc.
- Redirect (priority over push and pop):
  - FIFO count and pointers <= 0; fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No push that cycle.
  - A pop asserted in the same cycle is not counted; decode must treat that head as squashed.
- instr and instr_pc are registered FIFO-array reads indexed by the read pointer; no combinational path from mem_rdata to instr.
- Throughput: 1 instruction/cycle sustained while instr_ready=1.
- No write path; the fetch unit never drives memW.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds two outputs:
  - perf_fetched (32): increments on every push.
  - perf_stall (32): increments every cycle with count==DEPTH and no pop.
- Both counters reset to 0 on rst, wrap modulo 2^32, and are not cleared by redirect.
- When undefined, neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset and stream: memory words i at address 4i = 32'hA000_0000+i; rst high 2 cycles then low, instr_ready=1 -> cycle 1 instr_valid=1, instr_pc=0, instr=A000_0000; then one instruction per cycle with PC 4, 8, 12 and no gaps.
- Fill and stall: instr_ready=0 from reset with DEPTH=4 -> after 4 cycles count=4 and mem_addr holds 0x10; raising instr_ready pops PCs 0, 4, 8, 12, 16 in order with no duplicates or drops.
- Redirect mid-stream: full FIFO, redirect_valid=1 with redirect_pc=0x0000_0043 -> next cycle instr_valid=0 and mem_addr=0x40; the cycle after, instr_pc=0x40, and old entries never reappear.
- Simultaneous redirect and pop, plus rst with redirect in the same cycle -> redirect wins over the pop; rst wins over the redirect and fetch_pc=RESET_PC.
- PC wrap: redirect_pc=FFFF_FFF8, instr_ready=1 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- FETCH_PERF_EN defined: 10 cycles streaming, then 3 cycles full with instr_ready=0 -> perf_stall=3; perf_fetched equals the number of pushes; both read 0 after rst.
